// File: rtl/inst_mem_responder_pkg.sv
// Shared definitions for the instruction memory responder: default geometry,
// latencies and the controller state type. Also used by the instruction cache.
package inst_mem_responder_pkg;

    localparam int DEF_DATA_WIDTH         = 32;
    localparam int DEF_ADDRESS_WIDTH      = 32;
    localparam int DEF_BLOCK_OFFSET_WIDTH = 6;
    localparam int DEF_MEM_WORDS_WIDTH    = 10;
    localparam int DEF_FIRST_LATENCY      = 4;
    localparam int DEF_BURST_LATENCY      = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESPOND
    } resp_state_t;

endpackage

// File: rtl/inst_mem_responder_mem_word_array.sv
// Synchronous word RAM, one read port and one write port. A read and a write
// to the same word on the same edge return the old contents.
module mem_word_array #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic [DEPTH_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]  rd_data,
    input  logic                   wr_en,
    input  logic [DEPTH_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]  wr_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << DEPTH_WIDTH) - 1];

    // Storage has no reset so program contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction memory responder: answers one-word fetches after a first-word
// or in-line burst latency, with abort, restart and program-load support.
module inst_mem_responder
    import inst_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH      = DEF_ADDRESS_WIDTH,
    parameter int BLOCK_OFFSET_WIDTH = DEF_BLOCK_OFFSET_WIDTH,
    parameter int MEM_WORDS_WIDTH    = DEF_MEM_WORDS_WIDTH,
    parameter int FIRST_LATENCY      = DEF_FIRST_LATENCY,
    parameter int BURST_LATENCY      = DEF_BURST_LATENCY
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_data,
    input  logic                     load_we,
    input  logic [ADDRESS_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0]    load_data,
    output logic                     busy
);

    localparam int CNT_WIDTH = (FIRST_LATENCY > 1) ? $clog2(FIRST_LATENCY) : 1;
    localparam logic [CNT_WIDTH-1:0] FIRST_CNT = CNT_WIDTH'(FIRST_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] BURST_CNT = CNT_WIDTH'(BURST_LATENCY - 1);

    resp_state_t              state_q;
    resp_state_t              state_next;
    logic [CNT_WIDTH-1:0]     cnt_q;
    logic [CNT_WIDTH-1:0]     cnt_next;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [ADDRESS_WIDTH-1:0] addr_next;
    logic [ADDRESS_WIDTH-1:0] last_addr;
    logic                     last_valid;
    logic                     is_sequential;
    logic                     abort;
    logic                     rd_en;
    logic                     unused_load_bits;

    // A fetch is a burst continuation only within the same line as the last answer.
    assign is_sequential = last_valid
                        && (req_addr == last_addr + ADDRESS_WIDTH'(4))
                        && (req_addr[BLOCK_OFFSET_WIDTH-1:0] != '0);

    always_comb begin
        state_next = state_q;
        cnt_next   = cnt_q;
        addr_next  = addr_q;
        abort      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_next  = req_addr;
                    cnt_next   = is_sequential ? BURST_CNT : FIRST_CNT;
                    state_next = (cnt_next == '0) ? ST_RESPOND : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!req_valid) begin
                    abort      = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else if (req_addr != addr_q) begin
                    addr_next  = req_addr;
                    cnt_next   = FIRST_CNT;
                    state_next = (FIRST_CNT == '0) ? ST_RESPOND : ST_ACCESS;
                end else if (cnt_q <= CNT_WIDTH'(1)) begin
                    cnt_next   = '0;
                    state_next = ST_RESPOND;
                end else begin
                    cnt_next = cnt_q - CNT_WIDTH'(1);
                end
            end
            ST_RESPOND: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_next;
            cnt_q   <= cnt_next;
            addr_q  <= addr_next;
        end
    end

    // Any program load may change upcoming words, so it breaks burst continuity.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_addr  <= '0;
            last_valid <= 1'b0;
        end else begin
            if (state_q == ST_RESPOND) begin
                last_addr  <= addr_q;
                last_valid <= 1'b1;
            end
            if (abort || load_we) begin
                last_valid <= 1'b0;
            end
        end
    end

    assign rd_en = (state_next == ST_RESPOND);

    mem_word_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WIDTH (MEM_WORDS_WIDTH)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (rd_en),
        .rd_addr (addr_next[MEM_WORDS_WIDTH+1:2]),
        .rd_data (resp_data),
        .wr_en   (load_we && !rst),
        .wr_addr (load_addr[MEM_WORDS_WIDTH+1:2]),
        .wr_data (load_data)
    );

    assign resp_valid = (state_q == ST_RESPOND);
    assign busy       = (state_q != ST_IDLE);

    assign unused_load_bits = ^{load_addr[ADDRESS_WIDTH-1:MEM_WORDS_WIDTH+2], load_addr[1:0]};

endmodule
